// File: rtl/gpio_pad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_pad_pkg                                                         |
// | Shared types and the pad mode decode for the GPIO pad controller.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gpio_pad_pkg;

    typedef enum logic [1:0] {
        MODE_HIGHZ  = 2'b00,
        MODE_INPUT  = 2'b01,
        MODE_OUTPUT = 2'b10,
        MODE_BIDIR  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SEQ_RAMP   = 2'd0,
        SEQ_EN_H   = 2'd1,
        SEQ_ACTIVE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic inp;
        logic oe;
    } pad_ctl_t;

    function automatic pad_ctl_t mode_decode(input mode_e m);
        pad_ctl_t c;
        case (m)
            MODE_HIGHZ:  c = '{inp: 1'b0, oe: 1'b0};
            MODE_INPUT:  c = '{inp: 1'b1, oe: 1'b0};
            MODE_OUTPUT: c = '{inp: 1'b0, oe: 1'b1};
            MODE_BIDIR:  c = '{inp: 1'b1, oe: 1'b1};
            default:     c = '{inp: 1'b0, oe: 1'b0};
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_pad_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_pad_ctrl_if                                                     |
// | Serial configuration chain port of the GPIO pad controller.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface gpio_pad_ctrl_if;

    logic cfg_data_in;
    logic cfg_shift;
    logic cfg_load;
    logic cfg_data_out;

    modport master (
        output cfg_data_in,
        output cfg_shift,
        output cfg_load,
        input  cfg_data_out
    );

    modport slave (
        input  cfg_data_in,
        input  cfg_shift,
        input  cfg_load,
        output cfg_data_out
    );

endinterface
`default_nettype wire

// File: rtl/gpio_in_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_in_sync                                                         |
// | Two-flop synchroniser for one raw pad input.                         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gpio_in_sync (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_pad_ctrl                                                        |
// | Mode chain, HV enable sequencer and input sync for a GPIO pad bank.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gpio_pad_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int         NUM_PADS     = 8,
    parameter int         ENABLE_DLY   = 16,
    parameter logic [1:0] DEFAULT_MODE = 2'b01
) (
    input  wire                  clk,
    input  wire                  rst_n,
    input  wire                  seq_restart,
    gpio_pad_ctrl_if.slave       cfg,
    input  wire  [NUM_PADS-1:0]  core_out,
    output logic [NUM_PADS-1:0]  core_in,
    input  wire  [NUM_PADS-1:0]  pad_in,
    output logic [NUM_PADS-1:0]  pad_out,
    output logic [NUM_PADS-1:0]  pad_oe,
    output logic [NUM_PADS-1:0]  pad_enable_h,
    output logic [NUM_PADS-1:0]  pad_enable_inp_h,
    output logic                 seq_ready
);

    localparam int c_chain_w = 2 * NUM_PADS;
    localparam int c_cnt_w   = (ENABLE_DLY > 1) ? $clog2(ENABLE_DLY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ENABLE_DLY - 1);

    logic [c_chain_w-1:0] r_chain;
    mode_e                r_mode [NUM_PADS];

    seq_state_e           r_state;
    seq_state_e           w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [NUM_PADS-1:0]  w_inp_dec;
    logic [NUM_PADS-1:0]  w_oe_dec;
    logic [NUM_PADS-1:0]  w_sync;

    logic [NUM_PADS-1:0]  r_enable_h;
    logic [NUM_PADS-1:0]  r_enable_inp_h;
    logic [NUM_PADS-1:0]  r_oe;
    logic                 r_seq_ready;
    logic [NUM_PADS-1:0]  r_core_in;

    // Configuration shift chain; the MSB leaves the block for daisy-chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else if (cfg.cfg_shift) begin
            r_chain <= {r_chain[c_chain_w-2:0], cfg.cfg_data_in};
        end
    end

    assign cfg.cfg_data_out = r_chain[c_chain_w-1];

    // Load samples the chain as it was before any shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PADS; k++) begin
                r_mode[k] <= mode_e'(DEFAULT_MODE);
            end
        end else if (cfg.cfg_load) begin
            for (int k = 0; k < NUM_PADS; k++) begin
                r_mode[k] <= mode_e'(r_chain[2*k +: 2]);
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
            pad_ctl_t w_ctl;
            assign w_ctl        = mode_decode(r_mode[k]);
            assign w_inp_dec[k] = w_ctl.inp;
            assign w_oe_dec[k]  = w_ctl.oe;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEQ_RAMP:   if (r_cnt == c_cnt_last) w_state_nxt = SEQ_EN_H;
            SEQ_EN_H:   w_state_nxt = SEQ_ACTIVE;
            SEQ_ACTIVE: w_state_nxt = SEQ_ACTIVE;
            default:    w_state_nxt = SEQ_RAMP;
        endcase
        if (seq_restart) begin
            w_state_nxt = SEQ_RAMP;
        end
    end

    // Pin controls are registered from the next state so they change on the
    // same edge as the state, without any path from the cfg inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= SEQ_RAMP;
            r_cnt          <= '0;
            r_enable_h     <= '0;
            r_enable_inp_h <= '0;
            r_oe           <= '0;
            r_seq_ready    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == SEQ_RAMP) && !seq_restart) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            r_enable_h     <= (w_state_nxt != SEQ_RAMP)   ? '1 : '0;
            r_enable_inp_h <= (w_state_nxt == SEQ_ACTIVE) ? w_inp_dec : '0;
            r_oe           <= (w_state_nxt == SEQ_ACTIVE) ? w_oe_dec  : '0;
            r_seq_ready    <= (w_state_nxt == SEQ_ACTIVE);
        end
    end

    generate
        for (genvar k = 0; k < NUM_PADS; k++) begin : g_sync
            gpio_in_sync u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .i_d   (pad_in[k]),
                .o_q   (w_sync[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_in <= '0;
        end else begin
            r_core_in <= w_sync & r_enable_inp_h;
        end
    end

    assign core_in          = r_core_in;
    assign pad_out          = core_out & r_oe;
    assign pad_oe           = r_oe;
    assign pad_enable_h     = r_enable_h;
    assign pad_enable_inp_h = r_enable_inp_h;
    assign seq_ready        = r_seq_ready;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpio_pad_ctrl                                                     |
// | Scoreboard bench for gpio_pad_ctrl (8 pads, enable delay 4).         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_gpio_pad_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       seq_restart = 1'b0;
    logic [7:0] core_out = 8'h00;
    logic [7:0] pad_in = 8'h00;
    logic [7:0] core_in;
    logic [7:0] pad_out;
    logic [7:0] pad_oe;
    logic [7:0] pad_enable_h;
    logic [7:0] pad_enable_inp_h;
    logic       seq_ready;

    gpio_pad_ctrl_if cfg_if ();

    gpio_pad_ctrl #(
        .NUM_PADS     (8),
        .ENABLE_DLY   (4),
        .DEFAULT_MODE (2'b01)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .seq_restart      (seq_restart),
        .cfg              (cfg_if),
        .core_out         (core_out),
        .core_in          (core_in),
        .pad_in           (pad_in),
        .pad_out          (pad_out),
        .pad_oe           (pad_oe),
        .pad_enable_h     (pad_enable_h),
        .pad_enable_inp_h (pad_enable_inp_h),
        .seq_ready        (seq_ready)
    );

    always #5 clk = ~clk;

    typedef enum int {S_EN_H, S_INP, S_OE, S_OUT, S_CORE_IN, S_READY, S_CDO} sig_e;

    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t       sb [$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         mon_i;
    logic [7:0] mon_act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sample(input sig_e s);
        case (s)
            S_EN_H:    return pad_enable_h;
            S_INP:     return pad_enable_inp_h;
            S_OE:      return pad_oe;
            S_OUT:     return pad_out;
            S_CORE_IN: return core_in;
            S_READY:   return {7'b0, seq_ready};
            default:   return {7'b0, cfg_if.cfg_data_out};
        endcase
    endfunction

    // Expected value of a signal as seen after dly more rising edges.
    task automatic push_exp(input int dly, input sig_e s, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sig  = s;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        mon_i = 0;
        while (mon_i < sb.size()) begin
            if (sb[mon_i].cyc <= cyc) begin
                total++;
                mon_act = sample(sb[mon_i].sig);
                if (sb[mon_i].cyc < cyc) begin
                    bad++;
                    $display("FAIL %s: check missed, due cycle %0d now %0d", sb[mon_i].name, sb[mon_i].cyc, cyc);
                end else if (mon_act !== sb[mon_i].exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h (cycle %0d)", sb[mon_i].name, mon_act, sb[mon_i].exp, cyc);
                end
                sb.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            cfg_if.cfg_data_in = w[i];
            cfg_if.cfg_shift   = 1'b1;
            tick(1);
        end
        cfg_if.cfg_shift = 1'b0;
    endtask

    task automatic load_pulse();
        cfg_if.cfg_load = 1'b1;
        tick(1);
        cfg_if.cfg_load = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_if.cfg_data_in = 1'b0;
        cfg_if.cfg_shift   = 1'b0;
        cfg_if.cfg_load    = 1'b0;
        core_out           = 8'hFF;
        tick(3);

        // Reset state
        push_exp(0, S_EN_H,    8'h00, "rst_en_h");
        push_exp(0, S_INP,     8'h00, "rst_inp");
        push_exp(0, S_OE,      8'h00, "rst_oe");
        push_exp(0, S_OUT,     8'h00, "rst_pad_out");
        push_exp(0, S_CORE_IN, 8'h00, "rst_core_in");
        push_exp(0, S_READY,   8'h00, "rst_ready");
        push_exp(0, S_CDO,     8'h00, "rst_cdo");
        tick(1);

        // Reset release: next edge is edge 1
        rst_n = 1'b1;
        push_exp(1, S_EN_H,  8'h00, "seq_e1_en_h");
        push_exp(3, S_EN_H,  8'h00, "seq_e3_en_h");
        push_exp(4, S_EN_H,  8'hFF, "seq_e4_en_h");
        push_exp(4, S_INP,   8'h00, "seq_e4_inp");
        push_exp(4, S_READY, 8'h00, "seq_e4_ready");
        push_exp(5, S_INP,   8'hFF, "seq_e5_inp");
        push_exp(5, S_OE,    8'h00, "seq_e5_oe");
        push_exp(5, S_READY, 8'h01, "seq_e5_ready");
        tick(7);

        // Full config: pad0 OUTPUT, pad7 BIDIR, rest HIGHZ
        shift_word(16'hC002);
        push_exp(0, S_CDO, 8'h01, "cfg_cdo");
        push_exp(0, S_OE,  8'h00, "cfg_shift_no_load_oe");
        push_exp(0, S_INP, 8'hFF, "cfg_shift_no_load_inp");
        push_exp(1, S_OE,  8'h00, "cfg_load_edge_oe");
        push_exp(2, S_OE,  8'h81, "cfg_oe");
        push_exp(2, S_INP, 8'h80, "cfg_inp");
        push_exp(2, S_OUT, 8'h81, "cfg_pad_out");
        load_pulse();
        tick(2);

        // Simultaneous shift and load: mode takes the pre-shift chain 5555
        shift_word(16'h5555);
        push_exp(0, S_OE,  8'h81, "shift_keeps_mode");
        push_exp(0, S_CDO, 8'h00, "sl_cdo_before");
        cfg_if.cfg_data_in = 1'b1;
        cfg_if.cfg_shift   = 1'b1;
        push_exp(1, S_CDO, 8'h01, "sl_cdo_after");
        push_exp(2, S_OE,  8'h00, "sl_oe");
        push_exp(2, S_INP, 8'hFF, "sl_inp");
        load_pulse();
        cfg_if.cfg_shift = 1'b0;
        tick(2);
        cfg_if.cfg_data_in = 1'b0;
        cfg_if.cfg_shift   = 1'b1;
        push_exp(1, S_CDO, 8'h00, "sl_cdo_next");
        tick(1);
        cfg_if.cfg_shift = 1'b0;
        tick(1);

        // Input path on an INPUT pad
        pad_in[3] = 1'b1;
        push_exp(2, S_CORE_IN, 8'h00, "in_rise_e2");
        push_exp(3, S_CORE_IN, 8'h08, "in_rise_e3");
        tick(3);
        pad_in[3] = 1'b0;
        push_exp(2, S_CORE_IN, 8'h08, "in_fall_e2");
        push_exp(3, S_CORE_IN, 8'h00, "in_fall_e3");
        tick(4);

        // Pad3 HIGHZ masks its input; pad7 BIDIR passes
        shift_word(16'hC002);
        load_pulse();
        tick(3);
        pad_in = 8'h88;
        push_exp(3, S_CORE_IN, 8'h80, "in_highz_masked");
        push_exp(4, S_CORE_IN, 8'h80, "in_highz_hold");
        tick(5);
        pad_in = 8'h00;
        tick(4);

        // Restart in ACTIVE
        seq_restart = 1'b1;
        push_exp(1, S_EN_H,  8'h00, "rs_en_h_drop");
        push_exp(1, S_INP,   8'h00, "rs_inp_drop");
        push_exp(1, S_OE,    8'h00, "rs_oe_drop");
        push_exp(1, S_READY, 8'h00, "rs_ready_drop");
        push_exp(4, S_EN_H,  8'h00, "rs_en_h_ramp");
        push_exp(5, S_EN_H,  8'hFF, "rs_en_h_back");
        push_exp(5, S_OE,    8'h00, "rs_oe_en_h");
        push_exp(6, S_OE,    8'h81, "rs_oe_kept");
        push_exp(6, S_INP,   8'h80, "rs_inp_kept");
        push_exp(6, S_READY, 8'h01, "rs_ready");
        push_exp(6, S_OUT,   8'h81, "rs_pad_out");
        tick(1);
        seq_restart = 1'b0;
        tick(7);

        // Async reset after 5 shifts
        cfg_if.cfg_data_in = 1'b1;
        cfg_if.cfg_shift   = 1'b1;
        tick(5);
        cfg_if.cfg_shift = 1'b0;
        rst_n = 1'b0;
        push_exp(0, S_EN_H,  8'h00, "arst_en_h");
        push_exp(0, S_OE,    8'h00, "arst_oe");
        push_exp(0, S_INP,   8'h00, "arst_inp");
        push_exp(0, S_OUT,   8'h00, "arst_pad_out");
        push_exp(0, S_READY, 8'h00, "arst_ready");
        tick(2);
        rst_n = 1'b1;
        push_exp(0, S_CDO, 8'h00, "arst_cdo");
        push_exp(5, S_INP, 8'hFF, "arst_mode_inp");
        push_exp(5, S_OE,  8'h00, "arst_mode_oe");
        tick(6);
        cfg_if.cfg_data_in = 1'b0;
        for (int i = 0; i < 11; i++) begin
            cfg_if.cfg_shift = 1'b1;
            tick(1);
        end
        cfg_if.cfg_shift = 1'b0;
        push_exp(0, S_CDO, 8'h00, "arst_chain_clear");
        tick(3);

        while (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s: never checked, due cycle %0d", sb[0].name, sb[0].cyc);
            sb.delete(0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
